// File: rtl/smu_pkg.sv
// Shared types for the store merge unit: op encodings, FSM states
// and a lane-count helper.
package smu_pkg;

    typedef enum logic [1:0] {
        OP_SB  = 2'b00,
        OP_SH  = 2'b01,
        OP_SW  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_MERGE = 2'b10,
        S_WRITE = 2'b11
    } state_e;

    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/smu_fifo.sv
// In-order pending-store queue with registered full/empty flags.
// Reset empties it; push and pop are ignored while reset is high.
module smu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the indices match
    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) &&
                     (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_push = push && !full && !reset;
    assign do_pop  = pop && !empty;
    assign rdata   = store[rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/store_merge_unit.sv
// Byte/halfword store merging via read-modify-write on a word memory.
// Optional SMU_ALIGN_CHECK_EN drops misaligned SH/SW and pulses align_err.
module store_merge_unit
    import smu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [1:0]                        req_op,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [DATA_W-1:0]                 req_data,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0] mem_addr,
    output logic                              mem_rd_en,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              mem_wr_en,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic                              busy,
    output logic                              align_err
);

    localparam int LANES = lanes(DATA_W);
    localparam int LB    = $clog2(LANES);
    localparam int EW    = 2 + ADDR_W + DATA_W;

    logic [EW-1:0]     head;
    logic [1:0]        head_op_raw;
    op_e               head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              misalign;

    state_e            state;
    state_e            state_n;
    logic              cur_sh;
    logic [LB-1:0]     cur_lane;
    logic [15:0]       cur_data;
    logic [DATA_W-1:0] merged;

    assign push      = req_valid && !full;
    assign req_ready = !full;
    assign busy      = !empty || (state != S_IDLE);
    assign mem_rd_en = (state == S_READ);
    assign mem_wr_en = (state == S_WRITE);

    assign {head_op_raw, head_addr, head_data} = head;
    assign head_op = op_e'(head_op_raw);

    smu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({req_op, req_addr, req_data}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

`ifdef SMU_ALIGN_CHECK_EN
    assign misalign = ((head_op == OP_SH) && head_addr[0]) ||
                      ((head_op == OP_SW) && (head_addr[LB-1:0] != '0));

    always_ff @(posedge clk) begin
        if (reset) align_err <= 1'b0;
        else       align_err <= pop && misalign;
    end
`else
    // Low address bits below the access size are simply ignored
    assign misalign  = 1'b0;
    assign align_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (!misalign) begin
                        unique case (head_op)
                            OP_SW:        state_n = S_WRITE;
                            OP_SB, OP_SH: state_n = S_READ;
                            default:      state_n = S_IDLE;
                        endcase
                    end
                end
            end
            S_READ:  state_n = S_MERGE;
            S_MERGE: state_n = S_WRITE;
            S_WRITE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Replace only the addressed byte or halfword of the fetched word
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < LANES; i++) begin
            if (!cur_sh && (i == int'(cur_lane))) begin
                merged[i*8 +: 8] = cur_data[7:0];
            end else if (cur_sh && ((i >> 1) == (int'(cur_lane) >> 1))) begin
                merged[i*8 +: 8] = cur_data[(i % 2)*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cur_sh    <= 1'b0;
            cur_lane  <= '0;
            cur_data  <= '0;
        end else begin
            state <= state_n;
            if (pop && (state_n != S_IDLE)) begin
                mem_addr <= head_addr[ADDR_W-1:LB];
                cur_sh   <= (head_op == OP_SH);
                cur_lane <= head_addr[LB-1:0];
                cur_data <= head_data[15:0];
            end
            if (pop && (state_n == S_WRITE)) mem_wdata <= head_data;
            if (state == S_MERGE)            mem_wdata <= merged;
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed self-checking bench for store_merge_unit with a word memory model.
// Expectations follow SMU_ALIGN_CHECK_EN when the build defines it.
module tb_store_merge_unit;
    import smu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [29:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        align_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [64];
    logic        pre_en  = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    int          rd_cnt  = 0;
    int          wr_cnt  = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;

    always #5 clk = ~clk;

    store_merge_unit #(
        .DATA_W (32),
        .ADDR_W (32),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .align_err (align_err)
    );

    // Memory model: read data returned one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr[5:0]];
            rd_cnt    <= rd_cnt + 1;
        end
        if (mem_wr_en) begin
            mem[mem_addr[5:0]] <= mem_wdata;
            wr_cnt             <= wr_cnt + 1;
        end
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
        if (align_err) err_cnt <= err_cnt + 1;
        if (pre_en) mem[pre_idx] <= pre_val;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        tick();
        pre_en  = 1'b0;
    endtask

    // Present one request; returns after the accepting edge
    task automatic push(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data);
        int k;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        k = 0;
        while (!req_ready && k < 50) begin
            tick();
            k++;
        end
        chk("push_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int r0;
        int w0;
        int e0;
        int low;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = '0;
        req_data  = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_aerr",  {31'd0, align_err}, 32'd0);
        chk("rst_rd",    {31'd0, mem_rd_en}, 32'd0);
        chk("rst_wr",    {31'd0, mem_wr_en}, 32'd0);
        chk("rst_addr",  {2'd0, mem_addr},   32'd0);
        chk("rst_wdata", mem_wdata,          32'd0);

        // SB into lane 2 with exact read/merge/write timing
        poke(6'd4, 32'h11223344);
        poke(6'd5, 32'h00000000);
        poke(6'd8, 32'h00000000);
        r0 = rd_cnt;
        w0 = wr_cnt;
        push(OP_SB, 32'h12, 32'h000000AB);
        tick();
        chk("sb_rd_strobe", {31'd0, mem_rd_en}, 32'd1);
        chk("sb_rd_addr",   {2'd0, mem_addr},   32'h4);
        tick();
        chk("sb_merge_quiet", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        tick();
        chk("sb_wr_strobe", {31'd0, mem_wr_en}, 32'd1);
        chk("sb_wdata",     mem_wdata,          32'h11AB3344);
        wait_idle();
        chk("sb_mem",   mem[4],          32'h11AB3344);
        chk("sb_reads", rd_cnt - r0,     32'd1);
        chk("sb_addr_hold", {2'd0, mem_addr}, 32'h4);

        // SH into upper halfword
        poke(6'd4, 32'h11223344);
        push(OP_SH, 32'h12, 32'h0000BEEF);
        wait_idle();
        chk("sh_mem", mem[4], 32'hBEEF3344);

        // SW writes one cycle after pop with no read
        r0 = rd_cnt;
        push(OP_SW, 32'h20, 32'hDEADBEEF);
        tick();
        chk("sw_wr_strobe", {31'd0, mem_wr_en}, 32'd1);
        chk("sw_no_rd",     {31'd0, mem_rd_en}, 32'd0);
        chk("sw_addr",      {2'd0, mem_addr},   32'h8);
        chk("sw_wdata",     mem_wdata,          32'hDEADBEEF);
        wait_idle();
        chk("sw_mem",   mem[8],      32'hDEADBEEF);
        chk("sw_reads", rd_cnt - r0, 32'd0);

        // Back-to-back SBs fill the queue; same-word stores see prior writes
        poke(6'd4, 32'hFFFFFFFF);
        r0  = rd_cnt;
        w0  = wr_cnt;
        low = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int k;
            req_op   = OP_SB;
            req_addr = 32'h10 + 32'(i);
            req_data = 32'(i + 1);
            k = 0;
            while (!req_ready && k < 50) begin
                low++;
                tick();
                k++;
            end
            tick();
        end
        req_valid = 1'b0;
        wait_idle();
        chk("full_backpressure", {31'd0, low != 0}, 32'd1);
        chk("b2b_word4", mem[4],      32'h04030201);
        chk("b2b_word5", mem[5],      32'h00000605);
        chk("b2b_reads", rd_cnt - r0, 32'd6);
        chk("b2b_writes", wr_cnt - w0, 32'd6);

        // Reserved op is consumed with no memory access
        r0 = rd_cnt;
        w0 = wr_cnt;
        push(OP_RSV, 32'h10, 32'h12345678);
        wait_idle();
        chk("rsv_reads",  rd_cnt - r0, 32'd0);
        chk("rsv_writes", wr_cnt - w0, 32'd0);
        chk("rsv_mem",    mem[4],      32'h04030201);

        // Misaligned SW and SH
        poke(6'd8, 32'h00000000);
        w0 = wr_cnt;
        e0 = err_cnt;
        push(OP_SW, 32'h21, 32'hCAFEF00D);
        wait_idle();
        push(OP_SH, 32'h13, 32'h00005566);
        wait_idle();
`ifdef SMU_ALIGN_CHECK_EN
        chk("mis_err_pulses", err_cnt - e0, 32'd2);
        chk("mis_writes",     wr_cnt - w0,  32'd0);
        chk("mis_sw_mem",     mem[8],       32'h00000000);
        chk("mis_sh_mem",     mem[4],       32'h04030201);
`else
        chk("mis_err_pulses", err_cnt - e0, 32'd0);
        chk("mis_writes",     wr_cnt - w0,  32'd2);
        chk("mis_sw_mem",     mem[8],       32'hCAFEF00D);
        chk("mis_sh_mem",     mem[4],       32'h55660201);
`endif

        // Reset while a SB is reading: no write, and requests ignored
        poke(6'd4, 32'h11223344);
        w0 = wr_cnt;
        push(OP_SB, 32'h10, 32'h000000EE);
        tick();
        chk("abort_in_read", {31'd0, mem_rd_en}, 32'd1);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h20;
        req_data  = 32'h0BADF00D;
        repeat (2) tick();
        req_valid = 1'b0;
        reset     = 1'b0;
        chk("abort_busy",  {31'd0, busy},      32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        repeat (6) tick();
        chk("abort_writes", wr_cnt - w0, 32'd0);
        chk("abort_mem",    mem[4],      32'h11223344);
        chk("abort_idle",   {31'd0, busy}, 32'd0);
        chk("never_rd_wr",  both_cnt,    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
